vid_timing_gen: RTL

Parametrised raster timing generator for the HDMI/DVI output path, the successor to the fixed 640x480 counter/sync logic. It produces sync, data-enable, pixel request and line/frame strobes from a single pixel clock, for any resolution and sync polarity. It adds run-time enable/restart, a configurable pixel-request lead for pipelined pixel sources, current-pixel coordinates and a frame counter. It feeds the TMDS encoders and the pixel source.

---
 rtl/vid_timing_pkg.sv | 36 +++
 rtl/vid_axis_counter.sv | 58 +++++
 rtl/vid_timing_gen.sv | 135 +++++++++++++
 3 files changed

// File: rtl/vid_timing_pkg.sv
// Shared constants and helpers for the raster timing generator.
// Contents: total-period helper, 640x480@60 default timing set,
// 1280x720@60 timing set.
package vid_timing_pkg;

  // Period of one axis: active + front porch + sync + back porch.
  function automatic int calc_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // 640x480@60 (25.175 MHz pixel clock)
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_H_TOTAL  = calc_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
  localparam int VGA_V_TOTAL  = calc_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

  // 1280x720@60 (74.25 MHz pixel clock)
  localparam int HD720_H_ACTIVE = 1280;
  localparam int HD720_H_FP     = 110;
  localparam int HD720_H_SYNC   = 40;
  localparam int HD720_H_BP     = 220;
  localparam int HD720_V_ACTIVE = 720;
  localparam int HD720_V_FP     = 5;
  localparam int HD720_V_SYNC   = 5;
  localparam int HD720_V_BP     = 20;
  localparam int HD720_H_TOTAL  = calc_total(HD720_H_ACTIVE, HD720_H_FP, HD720_H_SYNC, HD720_H_BP);
  localparam int HD720_V_TOTAL  = calc_total(HD720_V_ACTIVE, HD720_V_FP, HD720_V_SYNC, HD720_V_BP);

endpackage

// File: rtl/vid_axis_counter.sv
// One raster axis: wrapping position counter plus active/sync decode.
// Ports:
//   clk, reset  - clock, async active-high reset
//   clear       - synchronous return to position 0 (dominates step)
//   step        - advance one position, wrapping after TOTAL-1
//   count       - current position
//   active      - count < ACTIVE
//   sync        - count inside the sync window
//   at_last     - count == TOTAL-1
module vid_axis_counter
  import vid_timing_pkg::*;
#(
  parameter int TOTAL  = VGA_H_TOTAL,
  parameter int ACTIVE = VGA_H_ACTIVE,
  parameter int FP     = VGA_H_FP,
  parameter int SYNC   = VGA_H_SYNC,
  parameter int CW     = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          step,
  output logic [CW-1:0] count,
  output logic          active,
  output logic          sync,
  output logic          at_last
);

  // Thresholds held at 32 bits so SYNC ending exactly at 2**CW cannot wrap.
  localparam logic [31:0] ACT_END  = ACTIVE;
  localparam logic [31:0] SYNC_BEG = ACTIVE + FP;
  localparam logic [31:0] SYNC_END = ACTIVE + FP + SYNC;
  localparam logic [31:0] LAST     = TOTAL - 1;

  logic [CW-1:0] count_q, count_d;
  logic [31:0]   count_w;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (step) begin
      count_d = at_last ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_w = 32'(count_q);
  assign count   = count_q;
  assign active  = count_w < ACT_END;
  assign sync    = (count_w >= SYNC_BEG) && (count_w < SYNC_END);
  assign at_last = count_w == LAST;

endmodule

// File: rtl/vid_timing_gen.sv
// Parametrised raster timing generator (sync, DE, pixel request, strobes).
// Ports:
//   i_pixclk, i_reset - pixel clock, async active-high reset
//   i_enable          - run; low parks the raster at (0,0) with idle outputs
//   o_rd              - pixel request, RD_LEAD cycles ahead of o_de
//   o_de              - data enable
//   o_hsync, o_vsync  - syncs at polarity HS_POL / VS_POL
//   o_newline         - pulse on last active pixel of each line
//   o_newframe        - pulse on last active pixel of the frame
//   o_x, o_y          - coordinates aligned with o_de
//   o_frame           - completed-frame count (wraps)
module vid_timing_gen
  import vid_timing_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1,
  parameter int   RD_LEAD  = 0,
  parameter int   CW       = 12,
  parameter int   FCW      = 16
) (
  input  logic           i_pixclk,
  input  logic           i_reset,
  input  logic           i_enable,
  output logic           o_hsync,
  output logic           o_vsync,
  output logic           o_de,
  output logic           o_rd,
  output logic           o_newline,
  output logic           o_newframe,
  output logic [CW-1:0]  o_x,
  output logic [CW-1:0]  o_y,
  output logic [FCW-1:0] o_frame
);

  localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (longint'(H_TOTAL) > (longint'(1) << CW) || longint'(V_TOTAL) > (longint'(1) << CW)) begin : g_bad_cw
    $error("vid_timing_gen: H_TOTAL or V_TOTAL exceeds 2**CW");
  end
  if (RD_LEAD < 0 || RD_LEAD > 7) begin : g_bad_lead
    $error("vid_timing_gen: RD_LEAD must be 0..7");
  end

  typedef struct packed {
    logic          active;
    logic          hs;
    logic          vs;
    logic          last_line;
    logic          last_frame;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } stage_t;

  logic [CW-1:0]  hc, vc;
  logic           h_act, h_sync, h_last;
  logic           v_act, v_sync, v_last;
  logic           unused_v_last;
  stage_t         stage_d, out_s;
  stage_t         pipe_q [RD_LEAD+1];
  logic [FCW-1:0] frame_q, frame_d;

  vid_axis_counter #(
    .TOTAL(H_TOTAL), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .CW(CW)
  ) u_h (
    .clk(i_pixclk), .reset(i_reset), .clear(~i_enable), .step(i_enable),
    .count(hc), .active(h_act), .sync(h_sync), .at_last(h_last)
  );

  vid_axis_counter #(
    .TOTAL(V_TOTAL), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .CW(CW)
  ) u_v (
    .clk(i_pixclk), .reset(i_reset), .clear(~i_enable), .step(i_enable & h_last),
    .count(vc), .active(v_act), .sync(v_sync), .at_last(v_last)
  );

  // Vertical wrap is implied by the counter itself; nothing else needs it.
  assign unused_v_last = v_last;

  always_comb begin
    stage_d            = '0;
    stage_d.active     = h_act & v_act;
    stage_d.hs         = h_sync;
    stage_d.vs         = v_sync;
    stage_d.last_line  = h_act & v_act & (hc == CW'(H_ACTIVE - 1));
    stage_d.last_frame = stage_d.last_line & (vc == CW'(V_ACTIVE - 1));
    stage_d.x          = hc;
    stage_d.y          = vc;
  end

  // pipe_q[0] is the o_rd stage; pipe_q[RD_LEAD] drives everything else,
  // so DE, syncs and coordinates always share the same delay.
  always_ff @(posedge i_pixclk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i <= RD_LEAD; i++) pipe_q[i] <= '0;
    end else if (!i_enable) begin
      for (int i = 0; i <= RD_LEAD; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= stage_d;
      for (int i = 1; i <= RD_LEAD; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign out_s = pipe_q[RD_LEAD];

  // Frame count survives enable drops; only reset clears it.
  always_comb begin
    frame_d = frame_q;
    if (out_s.last_frame) frame_d = frame_q + FCW'(1);
  end

  always_ff @(posedge i_pixclk or posedge i_reset) begin
    if (i_reset) frame_q <= '0;
    else         frame_q <= frame_d;
  end

  assign o_rd       = pipe_q[0].active;
  assign o_de       = out_s.active;
  assign o_hsync    = out_s.hs ? HS_POL : ~HS_POL;
  assign o_vsync    = out_s.vs ? VS_POL : ~VS_POL;
  assign o_newline  = out_s.last_line;
  assign o_newframe = out_s.last_frame;
  assign o_x        = out_s.x;
  assign o_y        = out_s.y;
  assign o_frame    = frame_q;

endmodule
